// File: rtl/bcd_stopwatch.sv
// BCD stopwatch: four-digit decimal counter with run/pause/clear control.
// A tick prescaler divides the external tick rate by TICK_DIV; each terminal
// tick advances the BCD count by one, wrapping 9999 -> 0000 with a one-cycle
// wrap pulse. start_stop and clear act on their rising edges only.
module bcd_stopwatch #(
    parameter int TICK_DIV = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        start_stop,
    input  logic        clear,
    output logic [15:0] bcd,
    output logic        running,
    output logic        wrap
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [9:0] PRESC_MAX = 10'(TICK_DIV - 1);

    // Adds one to a four-digit BCD value; the top bit of the result is the
    // carry out of the most significant digit (9999 -> 0000 rollover).
    // A digit at or above 9 rolls to 0, so a corrupted nibble self-heals.
    function automatic logic [16:0] bcd_increment(input logic [15:0] value);
        logic [15:0] result;
        logic        carry;
        result = 16'h0000;
        carry  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (value[i*4 +: 4] >= 4'd9) begin
                    result[i*4 +: 4] = 4'd0;
                    carry            = 1'b1;
                end else begin
                    result[i*4 +: 4] = value[i*4 +: 4] + 4'd1;
                    carry            = 1'b0;
                end
            end else begin
                result[i*4 +: 4] = value[i*4 +: 4];
                carry            = 1'b0;
            end
        end
        return {carry, result};
    endfunction

    state_t      state_r;
    logic [15:0] bcd_r;
    logic [9:0]  presc_r;
    logic        running_r;
    logic        wrap_r;

    // Edge detector history plus an arm flag per button: a button must be
    // seen low after reset before its rising edge counts, so a level that is
    // already high at reset release never fires.
    logic        ss_q_r;
    logic        ss_arm_r;
    logic        clr_q_r;
    logic        clr_arm_r;

    logic        ss_edge_s;
    logic        clr_edge_s;
    logic        count_en_s;
    logic        presc_last_s;
    logic [15:0] bcd_next_s;
    logic        carry_s;

    // Button edge detection and tick qualification for the counter.
    always_comb begin
        ss_edge_s    = start_stop & ~ss_q_r  & ss_arm_r;
        clr_edge_s   = clear      & ~clr_q_r & clr_arm_r;
        count_en_s   = 1'b0;
        presc_last_s = 1'b0;
        {carry_s, bcd_next_s} = bcd_increment(bcd_r);
        if ((state_r == RUN) && tick && !ss_edge_s && !clr_edge_s) begin
            count_en_s = 1'b1;
        end else begin
            count_en_s = 1'b0;
        end
        if (presc_r == PRESC_MAX) begin
            presc_last_s = 1'b1;
        end else begin
            presc_last_s = 1'b0;
        end
    end

    // Sample button levels every cycle and arm each one once it is seen low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ss_q_r    <= 1'b0;
            ss_arm_r  <= 1'b0;
            clr_q_r   <= 1'b0;
            clr_arm_r <= 1'b0;
        end else begin
            ss_q_r    <= start_stop;
            ss_arm_r  <= ss_arm_r | ~start_stop;
            clr_q_r   <= clear;
            clr_arm_r <= clr_arm_r | ~clear;
        end
    end

    // Control FSM with prescaler, BCD digits and registered status outputs;
    // clear outranks start_stop, which outranks a tick in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            bcd_r     <= 16'h0000;
            presc_r   <= 10'd0;
            running_r <= 1'b0;
            wrap_r    <= 1'b0;
        end else if (clr_edge_s) begin
            state_r   <= IDLE;
            bcd_r     <= 16'h0000;
            presc_r   <= 10'd0;
            running_r <= 1'b0;
            wrap_r    <= 1'b0;
        end else begin
            wrap_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (ss_edge_s) begin
                        state_r   <= RUN;
                        running_r <= 1'b1;
                    end else begin
                        running_r <= 1'b0;
                    end
                end
                RUN: begin
                    if (ss_edge_s) begin
                        state_r   <= PAUSE;
                        running_r <= 1'b0;
                    end else begin
                        running_r <= 1'b1;
                        if (count_en_s) begin
                            if (presc_last_s) begin
                                presc_r <= 10'd0;
                                bcd_r   <= bcd_next_s;
                                wrap_r  <= carry_s;
                            end else begin
                                presc_r <= presc_r + 10'd1;
                            end
                        end else begin
                            presc_r <= presc_r;
                        end
                    end
                end
                PAUSE: begin
                    if (ss_edge_s) begin
                        state_r   <= RUN;
                        running_r <= 1'b1;
                    end else begin
                        running_r <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    bcd_r     <= 16'h0000;
                    presc_r   <= 10'd0;
                    running_r <= 1'b0;
                end
            endcase
        end
    end

    assign bcd     = bcd_r;
    assign running = running_r;
    assign wrap    = wrap_r;

endmodule
